// File: rtl/counter_pkg.sv
// Shared types and helpers for the counter family.
// No logic of its own; state encoding plus the load clamp used by counter_down_mod.
// No flow control involved.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Saturate a requested preset so the count never leaves 0..mod-1.
    function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] mod);
        return (val > mod - 32'd1) ? (mod - 32'd1) : val;
    endfunction

endpackage

// File: rtl/counter_down_mod.sv
// Modulo-MOD down counter with wrap/one-shot end-of-count and clamped parallel load.
// Latency: count, borrow_out, done, busy update one cycle after the edge; zero is combinational on count.
// No backpressure: en is a plain enable, load always wins over en on the same edge.
module counter_down_mod
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             oneshot,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             borrow_out,
    output logic             done,
    output logic             busy
);

    // Wrap target: MOD-1, not the all-ones value, so counts >= MOD are unreachable.
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             borrow_q, borrow_d;
    logic             done_q;
    logic             busy_q;

    // Next-state decode: load beats en beats hold; HALT only leaves through load or reset.
    always_comb begin
        count_d  = count_q;
        state_d  = state_q;
        borrow_d = 1'b0;
        if (load) begin
            count_d = WIDTH'(clamp_load(32'(load_val), 32'(MOD)));
            state_d = IDLE;
        end else if (en && (state_q != HALT)) begin
            if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
                state_d = RUN;
            end else if (oneshot) begin
                state_d = HALT;
            end else begin
                count_d  = MAX_CNT;
                borrow_d = 1'b1;
                state_d  = RUN;
            end
        end
    end

    // State, count and registered status flags; reset drops the borrow pulse immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= MAX_CNT;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            borrow_q <= borrow_d;
            done_q   <= (state_d == HALT);
            busy_q   <= (state_d == RUN);
        end
    end

    assign count      = count_q;
    assign zero       = (count_q == '0);
    assign borrow_out = borrow_q;
    assign done       = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_counter_down_mod.sv
// Directed bench for counter_down_mod: MOD=16 and MOD=11 instances plus a two-stage MOD=10 cascade.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
// Every check is an immediate assertion that counts and reports mismatches.
module tb_counter_down_mod;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Modulus-16 instance
    logic       en16 = 1'b0, load16 = 1'b0, os16 = 1'b0;
    logic [3:0] lv16 = 4'd0;
    logic [3:0] cnt16;
    logic       z16, b16, d16, bz16;

    counter_down_mod #(.WIDTH(4), .MOD(16)) u16 (
        .clk(clk), .rst_n(rst_n), .en(en16), .load(load16), .load_val(lv16),
        .oneshot(os16), .count(cnt16), .zero(z16), .borrow_out(b16),
        .done(d16), .busy(bz16)
    );

    // Modulus-11 instance
    logic       en11 = 1'b0, load11 = 1'b0;
    logic [3:0] lv11 = 4'd0;
    logic [3:0] cnt11;
    logic       z11, b11, d11, bz11;

    counter_down_mod #(.WIDTH(4), .MOD(11)) u11 (
        .clk(clk), .rst_n(rst_n), .en(en11), .load(load11), .load_val(lv11),
        .oneshot(1'b0), .count(cnt11), .zero(z11), .borrow_out(b11),
        .done(d11), .busy(bz11)
    );

    // Two-stage MOD=10 cascade
    logic       c_en = 1'b0;
    logic [3:0] lo_cnt, hi_cnt;
    logic       lo_z, lo_b, lo_d, lo_bz;
    logic       hi_z, hi_b, hi_d, hi_bz;

    counter_down_mod #(.WIDTH(4), .MOD(10)) u_lo (
        .clk(clk), .rst_n(rst_n), .en(c_en), .load(1'b0), .load_val(4'd0),
        .oneshot(1'b0), .count(lo_cnt), .zero(lo_z), .borrow_out(lo_b),
        .done(lo_d), .busy(lo_bz)
    );

    counter_down_mod #(.WIDTH(4), .MOD(10)) u_hi (
        .clk(clk), .rst_n(rst_n), .en(lo_b), .load(1'b0), .load_val(4'd0),
        .oneshot(1'b0), .count(hi_cnt), .zero(hi_z), .borrow_out(hi_b),
        .done(hi_d), .busy(hi_bz)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp11 [5];
        int os_cnt [6];
        int os_done [6];
        int os_busy [6];
        exp11   = '{2, 1, 0, 10, 9};
        os_cnt  = '{1, 0, 0, 0, 0, 0};
        os_done = '{0, 0, 1, 1, 1, 1};
        os_busy = '{1, 1, 0, 0, 0, 0};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_count", 32'(cnt16), 15);
        chk("rst_zero",  32'(z16), 0);
        chk("rst_busy",  32'(bz16), 0);
        chk("rst_done",  32'(d16), 0);
        chk("rst_borrow", 32'(b16), 0);
        #19 rst_n = 1'b1;
        tick();
        chk("idle_hold", 32'(cnt16), 15);

        // Wrap mode from reset: 15..0, then 15 with borrow, then 14
        en16 = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk("wrap_count",  32'(cnt16), (k <= 15) ? 15 - k : ((k == 16) ? 15 : 14));
            chk("wrap_borrow", 32'(b16), (k == 16) ? 1 : 0);
            chk("wrap_zero",   32'(z16), (k == 15) ? 1 : 0);
        end
        chk("wrap_busy", 32'(bz16), 1);
        en16 = 1'b0;
        tick();
        chk("en0_hold", 32'(cnt16), 14);

        // Async reset between edges
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(cnt16), 15);
        chk("async_rst_busy",  32'(bz16), 0);
        #1 rst_n = 1'b1;

        // Async reset during a borrow pulse
        en16 = 1'b1;
        for (int k = 1; k <= 16; k++) tick();
        chk("pre_rst_borrow", 32'(b16), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_kills_borrow", 32'(b16), 0);
        chk("rst_kills_count",  32'(cnt16), 15);
        #1 rst_n = 1'b1;
        en16 = 1'b0;

        // Modulus-11 counter: load 3, count through the wrap to 10
        load11 = 1'b1; lv11 = 4'd3;
        tick();
        chk("m11_load", 32'(cnt11), 3);
        chk("m11_load_busy", 32'(bz11), 0);
        load11 = 1'b0; en11 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("m11_count",  32'(cnt11), 32'(exp11[k]));
            chk("m11_borrow", 32'(b11), (k == 3) ? 1 : 0);
        end
        en11 = 1'b0; load11 = 1'b1; lv11 = 4'd14;
        tick();
        chk("m11_clamp", 32'(cnt11), 10);
        load11 = 1'b0;

        // One-shot: load 2, run into HALT
        os16 = 1'b1; load16 = 1'b1; lv16 = 4'd2;
        tick();
        chk("os_load", 32'(cnt16), 2);
        load16 = 1'b0; en16 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("os_count", 32'(cnt16), 32'(os_cnt[k]));
            chk("os_done",  32'(d16), 32'(os_done[k]));
            chk("os_busy",  32'(bz16), 32'(os_busy[k]));
            chk("os_borrow", 32'(b16), 0);
        end
        chk("os_zero", 32'(z16), 1);
        os16 = 1'b0;
        tick();
        chk("halt_no_restart_cnt",  32'(cnt16), 0);
        chk("halt_no_restart_done", 32'(d16), 1);
        en16 = 1'b0; load16 = 1'b1; lv16 = 4'd5;
        tick();
        chk("halt_reload_cnt",  32'(cnt16), 5);
        chk("halt_reload_done", 32'(d16), 0);
        chk("halt_reload_busy", 32'(bz16), 0);

        // load beats en on the same edge
        lv16 = 4'd7;
        tick();
        chk("preset7", 32'(cnt16), 7);
        lv16 = 4'd4; en16 = 1'b1;
        tick();
        chk("load_over_en", 32'(cnt16), 4);
        chk("load_over_en_busy", 32'(bz16), 0);
        load16 = 1'b0;
        tick();
        chk("toggle_1", 32'(cnt16), 3);
        en16 = 1'b0;
        tick();
        chk("toggle_0", 32'(cnt16), 3);
        chk("toggle_0_borrow", 32'(b16), 0);
        chk("toggle_0_busy", 32'(bz16), 1);
        en16 = 1'b1;
        tick();
        chk("toggle_1b", 32'(cnt16), 2);
        chk("toggle_1b_borrow", 32'(b16), 0);
        en16 = 1'b0;

        // Cascade: 99 lower edges from reset reach 00
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        chk("casc_rst", 32'({hi_cnt, lo_cnt}), 32'h99);
        c_en = 1'b1;
        for (int k = 1; k <= 99; k++) begin
            tick();
            if (k == 10) begin
                chk("casc_e10", 32'({hi_cnt, lo_cnt}), 32'h99);
                chk("casc_e10_borrow", 32'(lo_b), 1);
            end
            if (k == 11) chk("casc_e11", 32'({hi_cnt, lo_cnt}), 32'h88);
            if (k == 50) chk("casc_e50", 32'({hi_cnt, lo_cnt}), 32'h59);
            if (k == 99) chk("casc_e99", 32'({hi_cnt, lo_cnt}), 32'h00);
        end
        c_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_down_mod.md
Name: counter_down_mod

Overview:
- Modulo-MOD down counter: counts MOD-1, MOD-2, ... 0.
- Two end-of-count modes:
  - Wrap: returns to MOD-1 and asserts a one-cycle borrow pulse.
  - One-shot: stops at 0 and holds.
- Parallel load for presetting the count.
- Intended as the descending partner of the team's up counters.
- Used for timeouts and countdown sequencing; borrow_out allows cascading into a higher-order stage.

Parameters:
- WIDTH, 4, count register width in bits.
- MOD, 16, count modulus; valid range 2..2**WIDTH. Counting range is MOD-1 down to 0.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; one decrement per enabled rising edge.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- oneshot  input  1  mode select: 1 = stop at 0, 0 = wrap at 0. Sampled each edge.
- count  output  WIDTH  current count (registered).
- zero  output  1  combinational; 1 when count==0.
- borrow_out  output  1  registered one-cycle pulse on a wrap from 0 to MOD-1.
- done  output  1  registered; 1 while halted in one-shot.
- busy  output  1  registered; 1 in RUN state.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately without a clock edge):
  - count=MOD-1, state=IDLE, borrow_out=0, done=0, busy=0.
  - Deassertion is used directly; the synchroniser is external.
- States: IDLE (loaded or reset, not yet decremented), RUN (decrementing), HALT (one-shot terminal).
- Per-edge priority, highest first: load > en > hold.
- load=1 (any state):
  - count=load_val, or MOD-1 if load_val>MOD-1 (clamp).
  - state=IDLE, done=0, borrow_out=0.
  - en is ignored on this edge.
- en=1, state IDLE/RUN, count>0:
  - count=count-1, state=RUN, borrow_out=0.
- en=1, state IDLE/RUN, count==0, oneshot=0:
  - count=MOD-1, borrow_out=1 for exactly this one cycle, state=RUN.
- en=1, state IDLE/RUN, count==0, oneshot=1:
  - count stays 0, state=HALT, done=1, borrow_out=0.
- en=1, state HALT:
  - No change; count stays 0 and done stays 1 until load or reset.
- en=0:
  - count and state hold; borrow_out=0 (the pulse never stretches).
- Latency: the decrement is visible on count the cycle after the enabled edge. zero follows count combinationally.
- busy=1 iff state==RUN. done=1 iff state==HALT.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - No count value ≥ MOD is ever reachable.
  - For MOD<2**WIDTH the wrap target is MOD-1, not 2**WIDTH-1.
- Mode change mid-count: oneshot is evaluated only at the count==0 edge. Switching from 1 to 0 while in HALT does not restart the counter; a load is required.
- Reset mid-operation: an asynchronous assertion at any time forces the reset values, including mid-borrow-pulse (borrow_out drops immediately).
- Cascading: a higher stage connects its en to the lower stage's borrow_out. Each higher-stage decrement coincides with the cycle after the lower stage wraps.

Decomposition:
- Shared package counter_pkg holds:
  - State encoding: IDLE=2'd0, RUN=2'd1, HALT=2'd2.
  - Function clamp_load(val, MOD).
- No sub-module: a single always block for state/count plus an output assign. The cascaded two-stage configuration is a bench-level wrapper only.

Test Plan:
- Reset with no en: count=15, zero=0, busy=0, done=0. Assert rst_n=0 between clock edges -> count returns to 15 with no clock edge.
- oneshot=0, en=1 for 17 edges from reset: count goes 15..0, then 15, then 14. borrow_out=1 only in the cycle count shows 15 after the 0, for one cycle.
- MOD=11, oneshot=0: load load_val=3, then 5 enabled edges -> count 2,1,0,10,9, with borrow_out pulsing once at 10. Load load_val=14 -> count=10 (clamp).
- oneshot=1: load 2, en held high for 6 edges -> count 1,0,0,0..., done=1 from the edge after 0 is reached, busy=0, zero=1. Then load 5 -> done=0, count=5, state IDLE.
- load and en together with count=7 -> count=load_val (4), not 3. en toggling 1,0,1 from 4 -> count 3,3,2, and borrow_out stays 0.
- Cascade two instances (WIDTH=4, MOD=10), lower stage en=1 -> upper stage decrements exactly once per 10 lower edges. From reset to 99 edges, the combined value reads 00 at edge 99.
